wait_sched_ctrl: RTL and testbench

Arbitrated wait-event engine for the testbench command layer. Up to NB_REQ command sources (scenario readers, checker tasks) each request a rising- or falling-edge wait on one of WAIT_SIZE monitored signals with an optional cycle timeout. The block grants one requester at a time in round-robin order and runs the edge wait on the shared detector. It returns a tagged completion status (edge seen, timeout, abort) to the granted requester.

---
 rtl/wait_sched_pkg.sv | 17 +
 rtl/wait_sched_ctrl_rr_arbiter.sv | 35 +++
 rtl/wait_sched_ctrl.sv | 160 ++++++++++++++++
 tb/tb_wait_sched_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wait_sched_pkg.sv
// Shared state and completion-status encodings for the wait scheduler.
package wait_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPORT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EDGE    = 2'b00,
        TIMEOUT = 2'b01,
        ABORT   = 2'b10,
        ERROR   = 2'b11
    } status_e;

endpackage

// File: rtl/wait_sched_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches req_i upward from ptr_i (wrapping).
// Zero latency; returns a one-hot grant (or zero when disabled/no request) plus its index.
module rr_arbiter #(
    parameter int NB_REQ = 4,
    parameter int ID_W   = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [ID_W-1:0]   ptr_i,
    input  logic              en_i,
    output logic [NB_REQ-1:0] grant_o,
    output logic [ID_W-1:0]   id_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NB_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NB_REQ) begin
                idx = idx - NB_REQ;
            end
            if (en_i && !found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                id_o         = idx[ID_W-1:0];
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wait_sched_ctrl.sv
// Round-robin wait-event engine: grants one requester, waits for its edge, pulses a tagged status.
// Grant is combinational in IDLE only; done pulses the cycle after the deciding edge. WAIT_SCHED_TIMEOUT_EN adds the cycle timeout.
module wait_sched_ctrl
    import wait_sched_pkg::*;
#(
    parameter int NB_REQ    = 4,
    parameter int WAIT_SIZE = 5,
    parameter int SEL_W     = $clog2(WAIT_SIZE),
    parameter int ID_W      = $clog2(NB_REQ),
    parameter int TO_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NB_REQ-1:0]        i_req_valid,
    output logic [NB_REQ-1:0]        o_req_ready,
    input  logic [NB_REQ*SEL_W-1:0]  i_req_sel,
    input  logic [NB_REQ-1:0]        i_req_edge,
    input  logic [NB_REQ*TO_W-1:0]   i_req_timeout,
    input  logic                     i_abort,
    input  logic [WAIT_SIZE-1:0]     i_wait,
    output logic                     o_busy,
    output logic                     o_done_valid,
    output logic [ID_W-1:0]          o_done_id,
    output logic [1:0]               o_done_status
);

    state_e               state_q, state_d;
    status_e              status_q, status_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 edge_q, edge_d;
    logic [WAIT_SIZE-1:0] s_wait_q;

    logic [NB_REQ-1:0]    grant;
    logic [ID_W-1:0]      grant_id;
    logic                 arb_en;
    logic                 accept;
    logic [SEL_W-1:0]     sel_in;
    logic                 edge_hit;
    logic                 to_hit;

    assign arb_en = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .NB_REQ (NB_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .req_i   (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en),
        .grant_o (grant),
        .id_o    (grant_id)
    );

    assign o_req_ready = grant;
    assign accept      = |grant;
    assign sel_in      = i_req_sel[int'(grant_id)*SEL_W +: SEL_W];

    // WTR (edge_q=0) wants a 0->1 transition on the selected signal, WTF the reverse.
    assign edge_hit = (i_wait[sel_q] != s_wait_q[sel_q]) && (i_wait[sel_q] == !edge_q);

`ifdef WAIT_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    assign to_hit = (to_q != '0) && (cnt_q == to_q - 1'b1);

    always_comb begin
        to_d  = to_q;
        cnt_d = cnt_q;
        if (accept) begin
            to_d  = i_req_timeout[int'(grant_id)*TO_W +: TO_W];
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_q  <= '0;
            cnt_q <= '0;
        end else begin
            to_q  <= to_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^i_req_timeout;
    assign to_hit         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        sel_d    = sel_q;
        edge_d   = edge_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d     = grant_id;
                    sel_d    = sel_in;
                    edge_d   = i_req_edge[grant_id];
                    rr_ptr_d = (grant_id == ID_W'(NB_REQ - 1)) ? '0 : grant_id + 1'b1;
                    if (int'(sel_in) >= WAIT_SIZE) begin
                        status_d = ERROR;
                        state_d  = REPORT;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                // Priority: abort, then edge, then timeout expiry.
                if (i_abort) begin
                    status_d = ABORT;
                    state_d  = REPORT;
                end else if (edge_hit) begin
                    status_d = EDGE;
                    state_d  = REPORT;
                end else if (to_hit) begin
                    status_d = TIMEOUT;
                    state_d  = REPORT;
                end
            end
            REPORT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            status_q <= EDGE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            sel_q    <= '0;
            edge_q   <= 1'b0;
            s_wait_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            sel_q    <= sel_d;
            edge_q   <= edge_d;
            s_wait_q <= i_wait;
        end
    end

    assign o_busy        = (state_q != IDLE);
    assign o_done_valid  = (state_q == REPORT);
    assign o_done_id     = id_q;
    assign o_done_status = status_q;

endmodule

// File: tb/tb_wait_sched_ctrl.sv
// Directed bench for wait_sched_ctrl: reset, edge/timeout/abort/error completions, round-robin order.
module tb_wait_sched_ctrl;

    localparam int NB_REQ    = 4;
    localparam int WAIT_SIZE = 5;
    localparam int SEL_W     = 3;
    localparam int ID_W      = 2;
    localparam int TO_W      = 32;

    logic                    clk;
    logic                    rst;
    logic [NB_REQ-1:0]       i_req_valid;
    logic [NB_REQ-1:0]       o_req_ready;
    logic [NB_REQ*SEL_W-1:0] i_req_sel;
    logic [NB_REQ-1:0]       i_req_edge;
    logic [NB_REQ*TO_W-1:0]  i_req_timeout;
    logic                    i_abort;
    logic [WAIT_SIZE-1:0]    i_wait;
    logic                    o_busy;
    logic                    o_done_valid;
    logic [ID_W-1:0]         o_done_id;
    logic [1:0]              o_done_status;

    int checks = 0;
    int errors = 0;
    int n;

    logic [3:0] rdy_exp  [0:9];
    logic       done_exp [0:9];
    logic [1:0] id_exp   [0:9];

    wait_sched_ctrl #(
        .NB_REQ    (NB_REQ),
        .WAIT_SIZE (WAIT_SIZE),
        .SEL_W     (SEL_W),
        .ID_W      (ID_W),
        .TO_W      (TO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_sel     (i_req_sel),
        .i_req_edge    (i_req_edge),
        .i_req_timeout (i_req_timeout),
        .i_abort       (i_abort),
        .i_wait        (i_wait),
        .o_busy        (o_busy),
        .o_done_valid  (o_done_valid),
        .o_done_id     (o_done_id),
        .o_done_status (o_done_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise valid for requester k and return just after its accept edge.
    task automatic request(input int k, input logic [2:0] sel, input logic e, input logic [31:0] to);
        int w;
        i_req_sel[k*SEL_W +: SEL_W]   = sel;
        i_req_edge[k]                 = e;
        i_req_timeout[k*TO_W +: TO_W] = to;
        i_req_valid[k]                = 1'b1;
        w = 0;
        #1;
        while (!o_req_ready[k] && w < 20) begin
            step();
            #1;
            w++;
        end
        checks++;
        if (o_req_ready[k] !== 1'b1) begin errors++; $error("FAIL grant k=%0d", k); end
        step();
        i_req_valid[k] = 1'b0;
    endtask

    // Edges stepped until o_done_valid is seen; -1 if not within maxc edges.
    task automatic run_until_done(input int maxc, output int cnt);
        cnt = 0;
        while (cnt < maxc) begin
            step();
            cnt++;
            if (o_done_valid) break;
        end
        if (!o_done_valid) cnt = -1;
    endtask

    initial begin
        rst           = 1'b1;
        i_req_valid   = '0;
        i_req_sel     = '0;
        i_req_edge    = '0;
        i_req_timeout = '0;
        i_abort       = 1'b0;
        i_wait        = '0;
        rdy_exp  = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000,
                     4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};
        done_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        id_exp   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd0};

        repeat (3) step();
        i_req_valid[0] = 1'b1;
        #1;
        checks++;
        if (o_req_ready !== 4'b0000) begin errors++; $error("FAIL rst_ready %0h", o_req_ready); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL rst_busy"); end
        checks++;
        if (o_done_valid !== 1'b0) begin errors++; $error("FAIL rst_done_vld"); end
        checks++;
        if (o_done_id !== 2'd0) begin errors++; $error("FAIL rst_done_id %0h", o_done_id); end
        checks++;
        if (o_done_status !== 2'b00) begin errors++; $error("FAIL rst_status %0h", o_done_status); end
        rst = 1'b0;

        // Rising edge on signal 2, ten cycles after accept.
        request(0, 3'd2, 1'b0, 32'd0);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $error("FAIL s1_busy"); end
        checks++;
        if (o_req_ready !== 4'b0000) begin errors++; $error("FAIL s1_ready_wait %0h", o_req_ready); end
        run_until_done(9, n);
        checks++;
        if (n !== -1) begin errors++; $error("FAIL s1_no_early_done %0d", n); end
        i_wait[2] = 1'b1;
        run_until_done(5, n);
        checks++;
        if (n !== 1) begin errors++; $error("FAIL s1_latency %0d", n); end
        checks++;
        if (o_done_id !== 2'd0) begin errors++; $error("FAIL s1_id %0h", o_done_id); end
        checks++;
        if (o_done_status !== 2'b00) begin errors++; $error("FAIL s1_status %0h", o_done_status); end
        step();
        checks++;
        if (o_done_valid !== 1'b0) begin errors++; $error("FAIL s1_pulse_width"); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL s1_idle"); end

        // Falling wait on signal 0 held high with timeout 8.
        i_wait[0] = 1'b1;
        step();
        request(1, 3'd0, 1'b1, 32'd8);
`ifdef WAIT_SCHED_TIMEOUT_EN
        run_until_done(20, n);
        checks++;
        if (n !== 8) begin errors++; $error("FAIL s2_to_latency %0d", n); end
        checks++;
        if (o_done_status !== 2'b01) begin errors++; $error("FAIL s2_status %0h", o_done_status); end
        checks++;
        if (o_done_id !== 2'd1) begin errors++; $error("FAIL s2_id %0h", o_done_id); end
`else
        run_until_done(20, n);
        checks++;
        if (n !== -1) begin errors++; $error("FAIL s2_no_timeout %0d", n); end
        i_wait[0] = 1'b0;
        run_until_done(3, n);
        checks++;
        if (n !== 1) begin errors++; $error("FAIL s2_edge_latency %0d", n); end
        checks++;
        if (o_done_status !== 2'b00) begin errors++; $error("FAIL s2_status %0h", o_done_status); end
        checks++;
        if (o_done_id !== 2'd1) begin errors++; $error("FAIL s2_id %0h", o_done_id); end
`endif
        step();

        // Edge and timeout 5 both land on edge T+5: edge wins.
        request(2, 3'd3, 1'b0, 32'd5);
        run_until_done(4, n);
        checks++;
        if (n !== -1) begin errors++; $error("FAIL s3_no_early_done %0d", n); end
        i_wait[3] = 1'b1;
        run_until_done(3, n);
        checks++;
        if (n !== 1) begin errors++; $error("FAIL s3_latency %0d", n); end
        checks++;
        if (o_done_status !== 2'b00) begin errors++; $error("FAIL s3_status %0h", o_done_status); end
        checks++;
        if (o_done_id !== 2'd2) begin errors++; $error("FAIL s3_id %0h", o_done_id); end
        step();

        // Abort sampled at the third edge of the wait.
        request(3, 3'd4, 1'b0, 32'd0);
        run_until_done(2, n);
        checks++;
        if (n !== -1) begin errors++; $error("FAIL s4_no_early_done %0d", n); end
        i_abort = 1'b1;
        run_until_done(3, n);
        checks++;
        if (n !== 1) begin errors++; $error("FAIL s4_latency %0d", n); end
        checks++;
        if (o_done_status !== 2'b10) begin errors++; $error("FAIL s4_status %0h", o_done_status); end
        checks++;
        if (o_done_id !== 2'd3) begin errors++; $error("FAIL s4_id %0h", o_done_id); end
        i_abort = 1'b0;
        step();
        checks++;
        if (o_done_valid !== 1'b0) begin errors++; $error("FAIL s4_pulse_width"); end

        // Out-of-range select reports ERROR straight from accept.
        request(0, 3'd7, 1'b0, 32'd0);
        checks++;
        if (o_done_valid !== 1'b1) begin errors++; $error("FAIL s5_done"); end
        checks++;
        if (o_done_status !== 2'b11) begin errors++; $error("FAIL s5_status %0h", o_done_status); end
        checks++;
        if (o_done_id !== 2'd0) begin errors++; $error("FAIL s5_id %0h", o_done_id); end
        step();
        checks++;
        if (o_done_valid !== 1'b0) begin errors++; $error("FAIL s5_done_clear"); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL s5_idle"); end

        // Reset mid-wait, then 0/2/3 contend with abort held high.
        request(1, 3'd3, 1'b0, 32'd0);
        run_until_done(3, n);
        checks++;
        if (n !== -1) begin errors++; $error("FAIL s6_waiting %0d", n); end
        rst = 1'b1;
        i_req_sel[0*SEL_W +: SEL_W] = 3'd4;
        i_req_sel[2*SEL_W +: SEL_W] = 3'd4;
        i_req_sel[3*SEL_W +: SEL_W] = 3'd4;
        i_req_edge    = '0;
        i_req_timeout = '0;
        i_req_valid   = 4'b1101;
        i_abort       = 1'b1;
        step();
        checks++;
        if (o_done_valid !== 1'b0) begin errors++; $error("FAIL s6_rst_done"); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL s6_rst_busy"); end
        checks++;
        if (o_req_ready !== 4'b0000) begin errors++; $error("FAIL s6_rst_ready %0h", o_req_ready); end
        checks++;
        if (o_done_id !== 2'd0) begin errors++; $error("FAIL s6_rst_id %0h", o_done_id); end
        checks++;
        if (o_done_status !== 2'b00) begin errors++; $error("FAIL s6_rst_status %0h", o_done_status); end
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (o_req_ready !== rdy_exp[c]) begin
                errors++;
                $error("FAIL rr_ready c=%0d observed=%0h expected=%0h", c, o_req_ready, rdy_exp[c]);
            end
            checks++;
            if (o_done_valid !== done_exp[c]) begin
                errors++;
                $error("FAIL rr_done c=%0d observed=%0h expected=%0h", c, o_done_valid, done_exp[c]);
            end
            if (done_exp[c]) begin
                checks++;
                if (o_done_id !== id_exp[c]) begin
                    errors++;
                    $error("FAIL rr_done_id c=%0d observed=%0h expected=%0h", c, o_done_id, id_exp[c]);
                end
                checks++;
                if (o_done_status !== 2'b10) begin
                    errors++;
                    $error("FAIL rr_status c=%0d observed=%0h", c, o_done_status);
                end
            end
            step();
        end
        i_req_valid = '0;
        run_until_done(3, n);
        checks++;
        if (n !== 1) begin errors++; $error("FAIL rr_last_done %0d", n); end
        checks++;
        if (o_done_id !== 2'd0) begin errors++; $error("FAIL rr_last_id %0h", o_done_id); end
        i_abort = 1'b0;
        step();
        checks++;
        if (o_busy !== 1'b0) begin errors++; $error("FAIL end_idle"); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
